qmca_peak_trigger: RTL and testbench

// - Multi-channel pulse-height front end for the qMCA readout, on the ADC encoder clock domain.
// - Per channel: threshold crossing with hysteresis, peak tracking and pulse-length count.
// - Emits one 32-bit event word per pulse through a valid/ready stream (round-robin merge).
// - Replaces the single-channel "sample > TH and previous sample was not" trigger.
// - Also drives a per-channel one-cycle trigger pulse for the waveform receivers.

---
 rtl/qmca_peak_trigger_pkg.sv | 23 ++
 rtl/qmca_peak_trigger_if.sv | 9 +
 rtl/qmca_peak_ch.sv | 83 ++++++++
 rtl/qmca_peak_trigger.sv | 102 ++++++++++
 tb/tb_qmca_peak_trigger.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/qmca_peak_trigger_pkg.sv
// Shared types for the qMCA peak trigger: channel state encoding and event word layout.
package qmca_peak_trigger_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } ch_state_e;

  localparam int EVT_CH_LSB   = 30;
  localparam int EVT_PEAK_LSB = 16;
  localparam int EVT_LEN_LSB  = 0;

  function automatic logic [31:0] pack_evt(input logic [1:0] ch, input logic [13:0] peak,
                                           input logic [15:0] len);
    logic [31:0] w;
    w = '0;
    w[EVT_CH_LSB +: 2]    = ch;
    w[EVT_PEAK_LSB +: 14] = peak;
    w[EVT_LEN_LSB +: 16]  = len;
    return w;
  endfunction

endpackage

// File: rtl/qmca_peak_trigger_if.sv
// Event word stream: valid/ready, one 32-bit word per accepted cycle.
interface qmca_peak_trigger_if;
  logic        evt_valid;
  logic [31:0] evt_data;
  logic        evt_ready;

  modport master (output evt_valid, evt_data, input evt_ready);
  modport slave  (input evt_valid, evt_data, output evt_ready);
endinterface

// File: rtl/qmca_peak_ch.sv
// One ADC channel: hysteresis trigger FSM, peak/length tracking and a one-deep pending slot.
// A close with a full slot (not being drained this cycle) is reported on lost_inc_o.
module qmca_peak_ch
  import qmca_peak_trigger_pkg::*;
#(
  parameter int ADC_WIDTH = 14,
  parameter int LEN_WIDTH = 16,
  parameter int CH_ID     = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADC_WIDTH-1:0] sample_i,
  input  logic [ADC_WIDTH-1:0] th_i,
  input  logic [ADC_WIDTH-1:0] hyst_i,
  input  logic                 en_i,
  output logic                 trig_o,
  output logic                 pend_valid_o,
  output logic [31:0]          pend_data_o,
  input  logic                 pend_clr_i,
  output logic                 lost_inc_o
);

  ch_state_e            state_q;
  logic [ADC_WIDTH-1:0] peak_q, peak_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 trig_q;
  logic                 pend_vld_q;
  logic [31:0]          pend_dat_q, evt_d;
  logic [ADC_WIDTH-1:0] lo;
  logic                 start, close, slot_free;

  assign lo        = (th_i > hyst_i) ? th_i - hyst_i : '0;
  assign start     = (state_q == ST_IDLE) && en_i && (sample_i > th_i);
  assign close     = (state_q == ST_PULSE) && en_i && (sample_i < lo);
  // A slot being drained this cycle is free: the new event overwrites it.
  assign slot_free = !pend_vld_q || pend_clr_i;
  assign peak_d    = (sample_i > peak_q) ? sample_i : peak_q;
  assign len_d     = (&len_q) ? len_q : len_q + LEN_WIDTH'(1);
  assign evt_d     = pack_evt(2'(CH_ID), 14'(peak_q), 16'(len_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      peak_q     <= '0;
      len_q      <= '0;
      trig_q     <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_dat_q <= '0;
    end else begin
      trig_q <= start;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_PULSE;
            peak_q  <= sample_i;
            len_q   <= LEN_WIDTH'(1);
          end
        end
        ST_PULSE: begin
          if (!en_i || close) begin
            state_q <= ST_IDLE;
          end else begin
            peak_q <= peak_d;
            len_q  <= len_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      if (close && slot_free) begin
        pend_vld_q <= 1'b1;
        pend_dat_q <= evt_d;
      end else if (pend_clr_i) begin
        pend_vld_q <= 1'b0;
      end
    end
  end

  assign trig_o       = trig_q;
  assign pend_valid_o = pend_vld_q;
  assign pend_data_o  = pend_dat_q;
  assign lost_inc_o   = close && !slot_free;

endmodule

// File: rtl/qmca_peak_trigger.sv
// Multi-channel pulse-height trigger: per-channel peak detectors merged round-robin into one
// registered event stream, with a saturating count of events dropped on full pending slots.
module qmca_peak_trigger
  import qmca_peak_trigger_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int ADC_WIDTH = 14,
  parameter int LEN_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHANNELS*ADC_WIDTH-1:0] adc_in_i,
  input  logic [CHANNELS*ADC_WIDTH-1:0] th_i,
  input  logic [ADC_WIDTH-1:0]          hyst_i,
  input  logic [CHANNELS-1:0]           ch_en_i,
  output logic [CHANNELS-1:0]           trig_o,
  output logic [15:0]                   lost_cnt_o,
  qmca_peak_trigger_if.master           evt
);

  logic [CHANNELS-1:0] pend_vld, pend_clr, lost_inc;
  logic [31:0]         pend_dat [CHANNELS];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    qmca_peak_ch #(
      .ADC_WIDTH (ADC_WIDTH),
      .LEN_WIDTH (LEN_WIDTH),
      .CH_ID     (c)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .sample_i     (adc_in_i[c*ADC_WIDTH +: ADC_WIDTH]),
      .th_i         (th_i[c*ADC_WIDTH +: ADC_WIDTH]),
      .hyst_i       (hyst_i),
      .en_i         (ch_en_i[c]),
      .trig_o       (trig_o[c]),
      .pend_valid_o (pend_vld[c]),
      .pend_data_o  (pend_dat[c]),
      .pend_clr_i   (pend_clr[c]),
      .lost_inc_o   (lost_inc[c])
    );
  end

  logic        evt_valid_q;
  logic [31:0] evt_data_q;
  logic [1:0]  last_q;
  logic [15:0] lost_q, lost_d;
  logic        load, gnt_vld;
  logic [1:0]  gnt_idx;
  logic [2:0]  lost_sum;
  logic [16:0] lost_add;

  assign load = !evt_valid_q || evt.evt_ready;

  // Search starts one past the last granted channel so every slot gets a turn.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      if (!gnt_vld && pend_vld[(int'(last_q) + k) % CHANNELS]) begin
        gnt_vld = 1'b1;
        gnt_idx = 2'((int'(last_q) + k) % CHANNELS);
      end
    end
  end

  always_comb begin
    pend_clr = '0;
    if (load && gnt_vld) pend_clr[gnt_idx] = 1'b1;
  end

  always_comb begin
    lost_sum = '0;
    for (int c = 0; c < CHANNELS; c++) lost_sum = lost_sum + 3'(lost_inc[c]);
  end

  assign lost_add = {1'b0, lost_q} + 17'(lost_sum);
  assign lost_d   = lost_add[16] ? 16'hFFFF : lost_add[15:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid_q <= 1'b0;
      evt_data_q  <= '0;
      last_q      <= 2'(CHANNELS - 1);
      lost_q      <= '0;
    end else begin
      lost_q <= lost_d;
      if (load) begin
        evt_valid_q <= gnt_vld;
        if (gnt_vld) begin
          evt_data_q <= pend_dat[gnt_idx];
          last_q     <= gnt_idx;
        end
      end
    end
  end

  assign evt.evt_valid = evt_valid_q;
  assign evt.evt_data  = evt_data_q;
  assign lost_cnt_o    = lost_q;

endmodule

// File: tb/tb_qmca_peak_trigger.sv
// Directed bench for qmca_peak_trigger: hand-computed event words, triggers and lost counts.
module tb_qmca_peak_trigger;

  localparam int CH = 4;
  localparam int AW = 14;

  logic              clk = 1'b0;
  logic              rst;
  logic [CH*AW-1:0]  adc, th;
  logic [AW-1:0]     hyst;
  logic [CH-1:0]     ch_en;
  logic [CH-1:0]     trig;
  logic [15:0]       lost;
  int                n_cmp = 0;
  int                n_fail = 0;

  qmca_peak_trigger_if evt_if ();

  qmca_peak_trigger #(.CHANNELS(CH), .ADC_WIDTH(AW), .LEN_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .adc_in_i   (adc),
    .th_i       (th),
    .hyst_i     (hyst),
    .ch_en_i    (ch_en),
    .trig_o     (trig),
    .lost_cnt_o (lost),
    .evt        (evt_if)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] w(input int c, input int pk, input int ln);
    return {2'(c), 14'(pk), 16'(ln)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_s(input int c, input int v);
    adc[c*AW +: AW] = AW'(v);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    adc = '0;
    th = {CH{14'd100}};
    hyst = 14'd10;
    ch_en = '1;
    evt_if.evt_ready = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    do_reset;
    n_cmp++; if (trig !== 4'b0) begin n_fail++; $display("FAIL reset_trig got=%h exp=0", trig); end
    n_cmp++; if (evt_if.evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", evt_if.evt_valid); end
    n_cmp++; if (evt_if.evt_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", evt_if.evt_data); end
    n_cmp++; if (lost !== 16'h0) begin n_fail++; $display("FAIL reset_lost got=%h exp=0", lost); end
  endtask

  task automatic test_single_pulse;
    int vals[6];
    vals = '{50, 120, 300, 250, 95, 89};
    do_reset;
    for (int i = 0; i < 6; i++) begin
      set_s(2, vals[i]);
      tick;
      n_cmp++;
      if (trig !== ((i == 1) ? 4'b0100 : 4'b0000)) begin
        n_fail++; $display("FAIL single_trig step=%0d got=%b", i, trig);
      end
    end
    set_s(2, 0);
    n_cmp++; if (evt_if.evt_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_n1 got=%b exp=0", evt_if.evt_valid); end
    tick;
    n_cmp++; if (evt_if.evt_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_n2 got=%b exp=1", evt_if.evt_valid); end
    n_cmp++; if (evt_if.evt_data !== w(2, 300, 4)) begin n_fail++; $display("FAIL single_word got=%h exp=%h", evt_if.evt_data, w(2, 300, 4)); end
    tick;
    n_cmp++; if (evt_if.evt_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_drop got=%b exp=0", evt_if.evt_valid); end
  endtask

  task automatic test_hysteresis;
    int vals[5];
    int trig_cnt;
    vals = '{120, 95, 105, 90, 80};
    trig_cnt = 0;
    do_reset;
    set_s(0, 100);
    tick;
    n_cmp++; if (trig !== 4'b0) begin n_fail++; $display("FAIL eq_th_trig got=%b exp=0", trig); end
    for (int i = 0; i < 5; i++) begin
      set_s(0, vals[i]);
      tick;
      trig_cnt += int'(trig[0]);
    end
    set_s(0, 0);
    tick;
    n_cmp++; if (trig_cnt !== 1) begin n_fail++; $display("FAIL hyst_trig_count got=%0d exp=1", trig_cnt); end
    n_cmp++; if (evt_if.evt_valid !== 1'b1) begin n_fail++; $display("FAIL hyst_valid got=%b exp=1", evt_if.evt_valid); end
    n_cmp++; if (evt_if.evt_data !== w(0, 120, 4)) begin n_fail++; $display("FAIL hyst_word got=%h exp=%h", evt_if.evt_data, w(0, 120, 4)); end
  endtask

  task automatic test_backpressure;
    int pk[3];
    int trig_cnt;
    logic stable;
    pk = '{110, 130, 150};
    trig_cnt = 0;
    do_reset;
    evt_if.evt_ready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      set_s(0, pk[p]);
      tick;
      trig_cnt += int'(trig[0]);
      set_s(0, 0);
      tick;
    end
    n_cmp++; if (trig_cnt !== 3) begin n_fail++; $display("FAIL b2b_trig_count got=%0d exp=3", trig_cnt); end
    n_cmp++; if (lost !== 16'd1) begin n_fail++; $display("FAIL bp_lost got=%0d exp=1", lost); end
    n_cmp++; if (evt_if.evt_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid got=%b exp=1", evt_if.evt_valid); end
    stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (evt_if.evt_data !== w(0, 110, 1)) stable = 1'b0;
      tick;
    end
    n_cmp++; if (stable !== 1'b1) begin n_fail++; $display("FAIL bp_data_stable got=%h exp=%h", evt_if.evt_data, w(0, 110, 1)); end
    evt_if.evt_ready = 1'b1;
    tick;
    n_cmp++; if (evt_if.evt_data !== w(0, 130, 1) || evt_if.evt_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_second_word got=%h/%b exp=%h/1", evt_if.evt_data, evt_if.evt_valid, w(0, 130, 1));
    end
    tick;
    n_cmp++; if (evt_if.evt_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got=%b exp=0", evt_if.evt_valid); end
    n_cmp++; if (lost !== 16'd1) begin n_fail++; $display("FAIL bp_lost_hold got=%0d exp=1", lost); end
  endtask

  task automatic test_round_robin;
    do_reset;
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < CH; c++) set_s(c, 200 + 100 * b + c);
      tick;
      n_cmp++; if (trig !== 4'hF) begin n_fail++; $display("FAIL rr_trig burst=%0d got=%b exp=1111", b, trig); end
      for (int c = 0; c < CH; c++) set_s(c, 0);
      tick;
      for (int c = 0; c < CH; c++) begin
        tick;
        n_cmp++;
        if (evt_if.evt_valid !== 1'b1 || evt_if.evt_data !== w(c, 200 + 100 * b + c, 1)) begin
          n_fail++; $display("FAIL rr_word burst=%0d slot=%0d got=%h/%b exp=%h", b, c,
                             evt_if.evt_data, evt_if.evt_valid, w(c, 200 + 100 * b + c, 1));
        end
      end
      tick;
      n_cmp++; if (evt_if.evt_valid !== 1'b0) begin n_fail++; $display("FAIL rr_idle burst=%0d got=%b exp=0", b, evt_if.evt_valid); end
    end
  endtask

  task automatic test_ch_disable;
    int vcnt;
    vcnt = 0;
    do_reset;
    set_s(1, 200);
    tick;
    n_cmp++; if (trig !== 4'b0010) begin n_fail++; $display("FAIL dis_trig got=%b exp=0010", trig); end
    tick;
    ch_en[1] = 1'b0;
    tick;
    set_s(1, 0);
    ch_en[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      vcnt += int'(evt_if.evt_valid);
    end
    n_cmp++; if (vcnt !== 0) begin n_fail++; $display("FAIL dis_event got=%0d exp=0", vcnt); end
    n_cmp++; if (lost !== 16'd0) begin n_fail++; $display("FAIL dis_lost got=%0d exp=0", lost); end
  endtask

  task automatic test_len_saturation;
    do_reset;
    th = {CH{14'd5}};
    hyst = 14'd20;
    set_s(3, 10);
    tick;
    n_cmp++; if (trig !== 4'b1000) begin n_fail++; $display("FAIL sat_trig got=%b exp=1000", trig); end
    set_s(3, 0);
    repeat (65600) tick;
    n_cmp++; if (evt_if.evt_valid !== 1'b0) begin n_fail++; $display("FAIL sat_open got=%b exp=0", evt_if.evt_valid); end
    th[3*AW +: AW] = 14'd200;
    hyst = 14'd0;
    tick;
    tick;
    n_cmp++; if (evt_if.evt_data !== w(3, 10, 16'hFFFF) || evt_if.evt_valid !== 1'b1) begin
      n_fail++; $display("FAIL sat_word got=%h/%b exp=%h", evt_if.evt_data, evt_if.evt_valid, w(3, 10, 16'hFFFF));
    end
  endtask

  task automatic test_reset_mid_pulse;
    int vcnt;
    vcnt = 0;
    do_reset;
    evt_if.evt_ready = 1'b0;
    set_s(0, 150);
    tick;
    set_s(0, 0);
    tick;
    set_s(2, 200);
    tick;
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (trig !== 4'b0) begin n_fail++; $display("FAIL rstmid_trig got=%b exp=0", trig); end
    n_cmp++; if (evt_if.evt_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got=%b exp=0", evt_if.evt_valid); end
    n_cmp++; if (evt_if.evt_data !== 32'h0) begin n_fail++; $display("FAIL rstmid_data got=%h exp=0", evt_if.evt_data); end
    n_cmp++; if (lost !== 16'h0) begin n_fail++; $display("FAIL rstmid_lost got=%h exp=0", lost); end
    adc = '0;
    evt_if.evt_ready = 1'b1;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      vcnt += int'(evt_if.evt_valid);
    end
    n_cmp++; if (vcnt !== 0) begin n_fail++; $display("FAIL rstmid_inflight got=%0d exp=0", vcnt); end
  endtask

  initial begin
    rst = 1'b1;
    adc = '0;
    th = '0;
    hyst = '0;
    ch_en = '0;
    evt_if.evt_ready = 1'b0;
    test_reset;
    test_single_pulse;
    test_hysteresis;
    test_backpressure;
    test_round_robin;
    test_ch_disable;
    test_len_saturation;
    test_reset_mid_pulse;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
